// File: rtl/cbus_sram_responder.sv
// Cache-bus responder backed by a word-organised on-chip RAM.
// Fixed-latency single/wrap-burst reads and byte-strobed writes.
module cbus_sram_responder #(
    parameter int ADDR_BITS = 16,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [76:0] creq,
    output logic [33:0] cresp
);

    localparam int AW = ADDR_BITS - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic [3:0]      r_beat;
    logic [3:0]      r_len;
    logic            r_wr;
    logic [AW-1:0]   r_base;
    logic [31:0]     r_mem [0:(2**AW)-1];

    logic            w_valid;
    logic            w_is_write;
    logic [31:0]     w_addr;
    logic [3:0]      w_strobe;
    logic [31:0]     w_wdata;
    logic [3:0]      w_len;
    logic [AW-1:0]   w_mask;
    logic [AW-1:0]   w_idx;
    logic            w_beat_ok;
    logic            w_last;
    logic            w_we;
    logic            w_unused;

    // Request layout: valid, is_write, size[2:0], addr[31:0],
    // strobe[3:0], data[31:0], len[3:0] (MSB first).
    assign w_valid    = creq[76];
    assign w_is_write = creq[75];
    assign w_addr     = creq[71:40];
    assign w_strobe   = creq[39:36];
    assign w_wdata    = creq[35:4];
    assign w_len      = creq[3:0];
    assign w_unused   = ^{creq[74:72], creq[71:40+ADDR_BITS], creq[41:40]};

    // Wrap burst stays inside the len-aligned block of words.
    assign w_mask = {{(AW-4){1'b0}}, r_len};
    assign w_idx  = (r_base & ~w_mask)
                  | ((r_base + {{(AW-4){1'b0}}, r_beat}) & w_mask);

    assign w_beat_ok = (r_state == S_BURST) && w_valid;
    assign w_last    = w_beat_ok && (r_beat == r_len);
    assign w_we      = w_beat_ok && r_wr;

    assign cresp = {w_beat_ok, w_last,
                    (w_beat_ok && !r_wr) ? r_mem[w_idx] : 32'h0};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_valid) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (!w_valid)        w_next = S_IDLE;
                else if (r_cnt == 0) w_next = S_BURST;
            end
            S_BURST: begin
                if (!w_valid || w_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_beat  <= 4'd0;
            r_len   <= 4'd0;
            r_wr    <= 1'b0;
            r_base  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_valid) begin
                r_base <= w_addr[ADDR_BITS-1:2];
                r_len  <= w_len;
                r_wr   <= w_is_write;
                r_cnt  <= 4'(LATENCY - 1);
                r_beat <= 4'd0;
            end else if (r_state == S_WAIT && r_cnt != 0) begin
                r_cnt <= r_cnt - 4'd1;
            end else if (w_beat_ok && !w_last) begin
                r_beat <= r_beat + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_strobe[k]) r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Directed bench for cbus_sram_responder: timing, wrap, strobes,
// abort, async reset and back-to-back requests.
module tb_cbus_sram_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic [76:0] creq;
    logic [33:0] cresp;

    logic        q_v;
    logic        q_wr;
    logic [31:0] q_addr;
    logic [3:0]  q_strb;
    logic [31:0] q_data;
    logic [3:0]  q_len;

    logic [31:0] wd [16];
    logic [31:0] ex [16];

    int n_chk;
    int n_fail;

    assign creq = {q_v, q_wr, 3'b010, q_addr, q_strb, q_data, q_len};

    cbus_sram_responder #(.ADDR_BITS(16), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .creq  (creq),
        .cresp (cresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [33:0] obs,
                       input logic [33:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        q_v = 1'b0;
        repeat (n) step();
    endtask

    // Starts in c0 (just after an edge); returns in the cycle after
    // the last beat (or after the abort cycle) with valid still set.
    task automatic txn(input string tag, input logic wr,
                       input logic [31:0] addr, input logic [3:0] len,
                       input logic [3:0] strb, input int abort_at);
        q_v    = 1'b1;
        q_wr   = wr;
        q_addr = addr;
        q_len  = len;
        q_strb = strb;
        q_data = wd[0];
        #1;
        chk({tag, "_c0"}, cresp, 34'h0);
        for (int i = 1; i <= LAT; i++) begin
            step();
            chk({tag, "_wait"}, cresp, 34'h0);
        end
        for (int b = 0; b <= int'(len); b++) begin
            step();
            q_data = wd[b];
            if (b == abort_at) begin
                q_v = 1'b0;
                #1;
                chk({tag, "_abort"}, cresp, 34'h0);
                step();
                return;
            end
            #1;
            chk($sformatf("%s_b%0d", tag, b), cresp,
                {1'b1, (b == int'(len)), wr ? 32'h0 : ex[b]});
        end
        step();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        q_v = 0; q_wr = 0; q_addr = 0; q_strb = 0; q_data = 0; q_len = 0;
        for (int i = 0; i < 16; i++) begin
            wd[i] = 32'h0;
            ex[i] = 32'h0;
        end
        reset = 1'b1;
        #1;
        chk("reset", cresp, 34'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // Single write then read back
        wd[0] = 32'hDEADBEEF;
        txn("wr1", 1'b1, 32'h100, 4'd0, 4'hF, 99);
        idle(2);
        ex[0] = 32'hDEADBEEF;
        txn("rd1", 1'b0, 32'h100, 4'd0, 4'h0, 99);
        idle(1);

        // Partial strobe
        wd[0] = 32'h000000AB;
        txn("wrp", 1'b1, 32'h100, 4'd0, 4'h1, 99);
        idle(1);
        ex[0] = 32'hDEADBEAB;
        txn("rdp", 1'b0, 32'h100, 4'd0, 4'hF, 99);
        idle(1);

        // Wrap read inside a 4-word block
        for (int i = 0; i < 4; i++) wd[i] = i;
        txn("pre4", 1'b1, 32'h100, 4'd3, 4'hF, 99);
        idle(1);
        ex[0] = 2; ex[1] = 3; ex[2] = 0; ex[3] = 1;
        txn("wrap", 1'b0, 32'h108, 4'd3, 4'h0, 99);
        idle(1);

        // Upper address bits alias
        ex[0] = 32'h3;
        txn("alias", 1'b0, 32'h0001_010C, 4'd0, 4'h0, 99);
        idle(1);

        // Abort on the third beat of an 8-beat write
        for (int i = 0; i < 8; i++) wd[i] = 32'hA0 + i;
        txn("pre8", 1'b1, 32'h200, 4'd7, 4'hF, 99);
        idle(1);
        for (int i = 0; i < 8; i++) wd[i] = 32'hB0 + i;
        txn("ab8", 1'b1, 32'h200, 4'd7, 4'hF, 2);
        chk("ab_idle", cresp, 34'h0);
        idle(1);
        ex[0] = 32'hB0; ex[1] = 32'hB1;
        for (int i = 2; i < 8; i++) ex[i] = 32'hA0 + i;
        txn("rd8", 1'b0, 32'h200, 4'd7, 4'h0, 99);
        idle(1);

        // Async reset in the middle of a burst
        q_v = 1'b1; q_wr = 1'b0; q_addr = 32'h100; q_len = 4'd3;
        repeat (LAT + 1) step();
        chk("rst_pre", cresp, {2'b10, 32'h0});
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async", cresp, 34'h0);
        q_v = 1'b0;
        step();
        reset = 1'b0;
        step();
        ex[0] = 32'h0;
        txn("rst_rd", 1'b0, 32'h100, 4'd0, 4'h0, 99);
        idle(1);
        ex[0] = 32'h3;
        txn("rst_rd3", 1'b0, 32'h10C, 4'd0, 4'h0, 99);
        idle(1);

        // Back-to-back: write held valid on the cycle after last
        for (int i = 0; i < 4; i++) ex[i] = i;
        txn("b2b_rd", 1'b0, 32'h100, 4'd3, 4'h0, 99);
        wd[0] = 32'h12345678;
        txn("b2b_wr", 1'b1, 32'h300, 4'd0, 4'hF, 99);
        idle(1);
        ex[0] = 32'h12345678;
        txn("b2b_chk", 1'b0, 32'h300, 4'd0, 4'h0, 99);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
